register_16: RTL and testbench



---
 rtl/register_16_pkg.sv | 9 +
 rtl/register_16_if.sv | 25 ++
 rtl/register_16_bit_cell.sv | 21 ++
 rtl/register_16.sv | 31 +++
 tb/tb_register_16.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/register_16_pkg.sv
// Shared Hack datapath definitions: word width and word type.
// Imported by every block that carries a CPU/memory data word.
package hack_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

endpackage : hack_pkg

// File: rtl/register_16_if.sv
// Data/load/out bundle of a storage register; master drives in/load, slave returns out.
// No handshake: load is a plain enable sampled on the rising clock edge.
interface register_16_if
  import hack_pkg::*;
#(
  parameter int WIDTH = WORD_W
);

  logic [WIDTH-1:0] in;
  logic             load;
  logic [WIDTH-1:0] out;

  modport master (
    output in,
    output load,
    input  out
  );

  modport slave (
    input  in,
    input  load,
    output out
  );

endinterface : register_16_if

// File: rtl/register_16_bit_cell.sv
// One storage bit: DFF with hold/load mux and per-bit async reset value.
// Latency one clock from a load edge; no backpressure, load is a plain enable.
module bit_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  input  logic load,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule : bit_cell

// File: rtl/register_16.sv
// WIDTH-bit Hack register built from bit cells; out is driven straight from flops.
// Latency one clock from a load edge to out; no backpressure, holds while load=0.
module register_16
  import hack_pkg::*;
#(
  parameter int               WIDTH     = WORD_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  register_16_if.slave    bus
);

  logic [WIDTH-1:0] q;

  // Each bit carries its own reset value so RESET_VAL can be any pattern.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    bit_cell #(
      .RST_VAL (RESET_VAL[i])
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.in[i]),
      .load  (bus.load),
      .q     (q[i])
    );
  end

  assign bus.out = q;

endmodule : register_16

// File: tb/tb_register_16.sv
// Directed plus randomized checks of register_16 against a "last value loaded since reset" model.
`timescale 1ns/1ps
module tb_register_16;
  import hack_pkg::*;

  localparam word_t RST_VAL = 16'h0000;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  register_16_if #(.WIDTH(WORD_W)) bus ();

  register_16 #(
    .WIDTH     (WORD_W),
    .RESET_VAL (RST_VAL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  // Reference: out is the value captured at the most recent loading edge since reset.
  word_t loaded[$];

  always @(negedge rst_n) loaded.delete();

  always @(posedge clk) begin
    if (rst_n === 1'b1 && bus.load === 1'b1) loaded.push_back(bus.in);
  end

  function automatic word_t expected();
    return (loaded.size() == 0) ? RST_VAL : loaded[$];
  endfunction

  task automatic chk(input string tag, input word_t exp);
    checks++;
    assert (bus.out === exp)
    else begin
      errors++;
      $error("FAIL %s: out=%h expected=%h", tag, bus.out, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    bus.in   = '0;
    bus.load = 1'b0;
    #1;
    chk("reset_initial", expected());
    repeat (2) @(posedge clk);

    // Load 1234, then assert reset mid-cycle with no clock edge.
    @(negedge clk);
    rst_n    = 1'b1;
    bus.load = 1'b1;
    bus.in   = 16'h1234;
    @(posedge clk); #1;
    chk("pre_reset_value", expected());
    bus.load = 1'b0;
    @(negedge clk); #0.5;
    rst_n = 1'b0;
    #0.1;
    chk("async_reset", expected());

    // Load 00A5: not visible before the edge, visible after it.
    @(negedge clk);
    rst_n    = 1'b1;
    bus.load = 1'b1;
    bus.in   = 16'h00A5;
    #1;
    chk("load_before_edge", expected());
    @(posedge clk); #1;
    chk("load_after_edge", expected());

    // Hold with in stepping 1..10.
    bus.load = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      bus.in = word_t'(i);
      @(posedge clk); #1;
      chk($sformatf("hold_%0d", i), expected());
    end

    // load toggles every 1 ns, in steps every 3 ns, both off the clock edges.
    @(negedge clk); #0.5;
    bus.in = word_t'($urandom);
    fork
      repeat (64) begin
        bus.load = ~bus.load;
        #1;
      end
      repeat (22) begin
        #3;
        bus.in = bus.in + 16'd1;
      end
      repeat (15) begin
        @(posedge clk); #0.25;
        chk("toggle", expected());
      end
    join
    bus.load = 1'b0;

    // Random load/data per cycle.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.load = 1'($urandom);
      bus.in   = word_t'($urandom);
      @(posedge clk); #1;
      chk($sformatf("random_%0d", i), expected());
    end

    // Full width and MSB.
    @(negedge clk);
    bus.load = 1'b1;
    bus.in   = 16'hFFFF;
    @(posedge clk); #1;
    chk("all_ones", expected());
    @(negedge clk);
    bus.in = 16'h8000;
    @(posedge clk); #1;
    chk("msb_only", expected());

    // Reset overrides load while clocks run.
    @(negedge clk);
    bus.in = 16'h5555;
    rst_n  = 1'b0;
    #0.1;
    chk("reset_over_load_now", expected());
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("reset_held_%0d", i), expected());
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_before_edge", expected());
    @(posedge clk); #1;
    chk("release_first_edge", expected());

    // Reloading the same value leaves out unchanged.
    @(posedge clk); #1;
    chk("reload_same", expected());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_register_16
